// File: rtl/edge_event_ctrl.sv
// Edge event controller: synchronizes status inputs, latches selected edges as pending events
// and presents them one at a time on a valid/ready port. Define EDGE_EVENT_CTRL_RR_EN for RR.
module edge_event_ctrl #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned IDWIDTH   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATAWIDTH-1:0] i,
  input  logic [DATAWIDTH-1:0] rise_en,
  input  logic [DATAWIDTH-1:0] fall_en,
  input  logic [DATAWIDTH-1:0] mask,
  input  logic [DATAWIDTH-1:0] ovr_clr,
  output logic                 ev_valid,
  output logic [IDWIDTH-1:0]   ev_id,
  input  logic                 ev_ready,
  output logic [DATAWIDTH-1:0] pending,
  output logic [DATAWIDTH-1:0] ovr,
  output logic                 irq
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e                 state_q;
  logic [DATAWIDTH-1:0]   s1_q, s2_q, old_q;
  logic [1:0]             warm_q;
  logic                   valid_q;
  logic [IDWIDTH-1:0]     id_q;
  logic [DATAWIDTH-1:0]   pend_q, pend_d;
  logic [DATAWIDTH-1:0]   ovr_q, ovr_d;
  logic [DATAWIDTH-1:0]   edge_det;
  logic [DATAWIDTH-1:0]   elig;
  logic                   any_elig;
  logic                   grant;
  logic [IDWIDTH-1:0]     sel;
`ifdef EDGE_EVENT_CTRL_RR_EN
  logic [IDWIDTH-1:0]     ptr_q;
  logic [DATAWIDTH-1:0]   above;
  logic [DATAWIDTH-1:0]   elig_hi;
`endif

  function automatic logic [IDWIDTH-1:0] lowest(input logic [DATAWIDTH-1:0] v);
    lowest = '0;
    for (int j = int'(DATAWIDTH) - 1; j >= 0; j--) begin
      if (v[j]) lowest = IDWIDTH'(j);
    end
  endfunction

  // Edges are suppressed until s1/s2/old all hold post-reset samples.
  always_comb begin
    edge_det = '0;
    if (warm_q == 2'd3) begin
      edge_det = (s2_q & ~old_q & rise_en) | (~s2_q & old_q & fall_en);
    end
  end

  assign elig     = pend_q & mask;
  assign any_elig = |elig;
  assign grant    = any_elig & ((state_q == StEmpty) | ev_ready);

`ifdef EDGE_EVENT_CTRL_RR_EN
  // Prefer eligible bits above the last grant; otherwise wrap to the lowest index.
  always_comb begin
    above = '0;
    for (int j = 0; j < int'(DATAWIDTH); j++) begin
      if (j > int'(ptr_q)) above[j] = 1'b1;
    end
    elig_hi = elig & above;
    sel     = (|elig_hi) ? lowest(elig_hi) : lowest(elig);
  end
`else
  always_comb begin
    sel = lowest(elig);
  end
`endif

  always_comb begin
    pend_d = pend_q | edge_det;
    if (grant) begin
      pend_d = (pend_q & ~(DATAWIDTH'(1) << sel)) | edge_det;
    end
    ovr_d = (ovr_q & ~ovr_clr) | (edge_det & pend_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      s1_q    <= '0;
      s2_q    <= '0;
      old_q   <= '0;
      warm_q  <= 2'd0;
      valid_q <= 1'b0;
      id_q    <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
`ifdef EDGE_EVENT_CTRL_RR_EN
      ptr_q   <= IDWIDTH'(DATAWIDTH - 1);
`endif
    end else begin
      s1_q   <= i;
      s2_q   <= s1_q;
      old_q  <= s2_q;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
      if (grant) begin
        valid_q <= 1'b1;
        id_q    <= sel;
        state_q <= StFull;
`ifdef EDGE_EVENT_CTRL_RR_EN
        ptr_q   <= sel;
`endif
      end else if ((state_q == StFull) && ev_ready) begin
        valid_q <= 1'b0;
        state_q <= StEmpty;
      end
    end
  end

  assign ev_valid = valid_q;
  assign ev_id    = id_q;
  assign pending  = pend_q;
  assign ovr      = ovr_q;
  assign irq      = valid_q | (|(pend_q & mask));

endmodule

// File: tb/tb_edge_event_ctrl.sv
// Bench for edge_event_ctrl: sample-history event model checked every cycle, plus directed
// literal expectations. Honours EDGE_EVENT_CTRL_RR_EN for the arbitration order.
module tb_edge_event_ctrl;

  localparam int DW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] i, rise_en, fall_en, mask, ovr_clr;
  logic          ev_ready;
  logic          ev_valid;
  logic [IW-1:0] ev_id;
  logic [DW-1:0] pending, ovr;
  logic          irq;

  int n_cmp = 0;
  int n_bad = 0;

  edge_event_ctrl #(.DATAWIDTH(DW), .IDWIDTH(IW)) dut (
    .clk      (clk),
    .reset    (reset),
    .i        (i),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .mask     (mask),
    .ovr_clr  (ovr_clr),
    .ev_valid (ev_valid),
    .ev_id    (ev_id),
    .ev_ready (ev_ready),
    .pending  (pending),
    .ovr      (ovr),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an edge is the difference between the input samples taken two and three clocks
  // earlier, and only counts once both samples were taken after reset.
  logic          m_valid;
  logic [IW-1:0] m_id;
  logic [DW-1:0] m_pend, m_ovr;
  int            m_ptr;
  logic [DW-1:0] samp[$];

  always @(posedge clk) begin : model
    logic [DW-1:0] edges, elig, clr, pend_old, nw, od;
    int pick, c;
    if (reset) begin
      m_valid = 1'b0;
      m_id    = '0;
      m_pend  = '0;
      m_ovr   = '0;
      m_ptr   = DW - 1;
      samp.delete();
    end else begin
      samp.push_back(i);
      if (samp.size() > 4) void'(samp.pop_front());
      edges = '0;
      if (samp.size() == 4) begin
        nw    = samp[1];
        od    = samp[0];
        edges = (nw & ~od & rise_en) | (~nw & od & fall_en);
      end
      pend_old = m_pend;
      elig     = m_pend & mask;
      clr      = '0;
      pick     = -1;
      for (int k = 1; k <= DW; k++) begin
`ifdef EDGE_EVENT_CTRL_RR_EN
        c = (m_ptr + k) % DW;
`else
        c = k - 1;
`endif
        if (pick < 0 && elig[c[2:0]]) pick = c;
      end
      if ((!m_valid || ev_ready) && pick >= 0) begin
        m_valid = 1'b1;
        m_id    = IW'(pick);
        m_ptr   = pick;
        clr     = DW'(1) << pick;
      end else if (m_valid && ev_ready) begin
        m_valid = 1'b0;
      end
      m_ovr  = (m_ovr & ~ovr_clr) | (edges & pend_old);
      m_pend = (pend_old & ~clr) | edges;
    end
  end

  always @(negedge clk) begin
    check("model ev_valid", 32'(ev_valid), 32'(m_valid));
    if (m_valid) check("model ev_id", 32'(ev_id), 32'(m_id));
    check("model pending", 32'(pending), 32'(m_pend));
    check("model ovr", 32'(ovr), 32'(m_ovr));
    check("model irq", 32'(irq), 32'(m_valid | (|(m_pend & mask))));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_ids[3];

  initial begin
`ifdef EDGE_EVENT_CTRL_RR_EN
    exp_ids[0] = 6; exp_ids[1] = 1; exp_ids[2] = 4;
`else
    exp_ids[0] = 1; exp_ids[1] = 4; exp_ids[2] = 6;
`endif
    reset = 1'b1; i = 8'hFF; rise_en = 8'hFF; fall_en = 8'hFF; mask = 8'hFF;
    ovr_clr = 8'h00; ev_ready = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(10);
    check("reset hold ev_valid", 32'(ev_valid), 0);
    check("reset hold pending", 32'(pending), 0);
    check("reset hold ovr", 32'(ovr), 0);
    check("reset hold irq", 32'(irq), 0);
    check("reset hold ev_id", 32'(ev_id), 0);

    fall_en = 8'h00; i = 8'h00;
    cyc(5);
    check("fall disabled pending", 32'(pending), 0);

    // Single rising edge on bit 3, latency k+3.
    ev_ready = 1'b1; i[3] = 1'b1;
    cyc(3);
    check("bit3 k+2 ev_valid", 32'(ev_valid), 0);
    check("bit3 k+2 pending", 32'(pending), 32'h08);
    cyc(1);
    check("bit3 k+3 ev_valid", 32'(ev_valid), 1);
    check("bit3 k+3 ev_id", 32'(ev_id), 3);
    check("bit3 k+3 pending", 32'(pending), 0);
    cyc(1);
    check("bit3 single event", 32'(ev_valid), 0);

    // Overrun on bit 5 with the slot held.
    ev_ready = 1'b0; i[5] = 1'b1;
    cyc(4);
    check("bit5 presented id", 32'(ev_id), 5);
    check("bit5 presented pending", 32'(pending[5]), 0);
    i[5] = 1'b0; cyc(3); i[5] = 1'b1; cyc(4);
    check("bit5 second edge pending", 32'(pending[5]), 1);
    check("bit5 second edge ovr", 32'(ovr[5]), 0);
    i[5] = 1'b0; cyc(3); i[5] = 1'b1; cyc(4);
    check("bit5 third edge ovr", 32'(ovr[5]), 1);
    ovr_clr[5] = 1'b1; cyc(1); ovr_clr[5] = 1'b0;
    check("bit5 ovr_clr", 32'(ovr[5]), 0);
    i[5] = 1'b0; cyc(3); i[5] = 1'b1; cyc(2);
    ovr_clr[5] = 1'b1; cyc(1); ovr_clr[5] = 1'b0;
    check("bit5 set beats clr", 32'(ovr[5]), 1);
    ovr_clr[5] = 1'b1; i[5] = 1'b0; cyc(1); ovr_clr[5] = 1'b0;
    ev_ready = 1'b1;
    cyc(6);
    check("drain ev_valid", 32'(ev_valid), 0);
    check("drain pending", 32'(pending), 0);
    check("drain ovr", 32'(ovr), 0);

    // Prior grant of 4, then simultaneous edges on 1, 4, 6.
    i[4] = 1'b1; cyc(6);
    i[4] = 1'b0; cyc(3);
    i[1] = 1'b1; i[4] = 1'b1; i[6] = 1'b1;
    cyc(4);
    check("arb first id", 32'(ev_id), 32'(exp_ids[0]));
    cyc(1);
    check("arb second id", 32'(ev_id), 32'(exp_ids[1]));
    cyc(1);
    check("arb third id", 32'(ev_id), 32'(exp_ids[2]));
    check("arb third valid", 32'(ev_valid), 1);
    cyc(1);
    check("arb done", 32'(ev_valid), 0);

    // Masked pending bit waits for its mask.
    i[1] = 1'b0; i[4] = 1'b0; i[6] = 1'b0; cyc(3);
    mask[2] = 1'b0; i[2] = 1'b1;
    cyc(6);
    check("masked pending", 32'(pending[2]), 1);
    check("masked ev_valid", 32'(ev_valid), 0);
    check("masked irq", 32'(irq), 0);
    mask[2] = 1'b1;
    cyc(1);
    check("unmasked ev_valid", 32'(ev_valid), 1);
    check("unmasked ev_id", 32'(ev_id), 2);
    cyc(2);

    // Reset while an event is presented and 2,3 are pending.
    ev_ready = 1'b0; i[0] = 1'b1;
    cyc(4);
    check("hold id0", 32'(ev_id), 0);
    check("hold valid", 32'(ev_valid), 1);
    mask[0] = 1'b0; cyc(1);
    check("mask no retract", 32'(ev_valid), 1);
    mask = 8'hFF;
    i[2] = 1'b0; i[3] = 1'b0; cyc(3);
    i[2] = 1'b1; i[3] = 1'b1; cyc(4);
    check("pre-reset pending", 32'(pending), 32'h0C);
    check("pre-reset valid", 32'(ev_valid), 1);
    reset = 1'b1; cyc(1);
    check("mid reset ev_valid", 32'(ev_valid), 0);
    check("mid reset pending", 32'(pending), 0);
    check("mid reset ovr", 32'(ovr), 0);
    check("mid reset irq", 32'(irq), 0);
    check("mid reset ev_id", 32'(ev_id), 0);
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      cyc(1);
      check("warm-up pending", 32'(pending), 0);
      check("warm-up ev_valid", 32'(ev_valid), 0);
    end

    // Falling edge after warm-up still produces an event.
    fall_en[3] = 1'b1; i[3] = 1'b0; ev_ready = 1'b1;
    cyc(4);
    check("fall bit3 valid", 32'(ev_valid), 1);
    check("fall bit3 id", 32'(ev_id), 3);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
